// File: rtl/sram16_responder.sv
// sram16_responder
// Serves one-cycle processor read/write strobes (word or byte) from an
// asynchronous 1M x 16 SRAM. A word access runs as two halfword phases
// (LO then HI), a byte access as one. Each phase is SETUP, then WS ACTIVE
// cycles, then one RECOV cycle for writes only. stallX holds the processor
// until the last phase ends. Every SRAM pin and every processor-facing
// output comes straight from a flop.
module sram16_responder #(
   parameter int WS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] adr,
   input  logic        rd,
   input  logic        wr,
   input  logic        ben,
   input  logic [31:0] outbus,
   output logic [31:0] inbus,
   output logic        stallX,
   output logic [19:0] sram_adr,
   input  logic [15:0] sram_dq_in,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_RECOV  = 2'd3
   } state_t;

   // The counter holds the number of ACTIVE cycles still to run after the current one.
   localparam logic [3:0] WS_LAST = 4'(WS - 1);

   state_t      state_r;
   logic [3:0]  ws_cnt_r;
   logic [20:1] adr_r;        // halfword address and half select of the request
   logic        ben_r;
   logic        wr_r;
   logic        phase_r;      // 0 = LO phase, 1 = HI phase
   logic [15:0] data_hi_r;    // upper write half, driven in the HI phase

   logic        accept_s;
   logic        active_last_s;
   logic        phase_done_s;
   logic        more_phase_s;
   logic [31:0] rd_merge_s;

   // Halfword address used by the first (or only) phase of a request.
   function automatic logic [19:0] first_adr(input logic [20:0] a, input logic b);
      logic [19:0] r;
      if (b) begin
         r = a[20:1];
      end else begin
         r = {a[20:2], 1'b0};
      end
      return r;
   endfunction

   // Data driven in the first (or only) phase; a byte is duplicated onto both lanes.
   function automatic logic [15:0] first_dq(input logic [31:0] d, input logic b);
      logic [15:0] r;
      if (b) begin
         r = {d[7:0], d[7:0]};
      end else begin
         r = d[15:0];
      end
      return r;
   endfunction

   // Active-low lane enables {ub_n, lb_n}: both lanes for a word, one lane for a byte.
   function automatic logic [1:0] lanes_n(input logic b, input logic a0);
      logic [1:0] r;
      if (b) begin
         r = {~a0, a0};
      end else begin
         r = 2'b00;
      end
      return r;
   endfunction

   // New inbus value after a read phase; a byte read zeroes the other half.
   function automatic logic [31:0] merge_read(input logic [31:0] old,
                                              input logic [15:0] dq,
                                              input logic        b,
                                              input logic        a1,
                                              input logic        ph);
      logic [31:0] r;
      if (b) begin
         if (a1) begin
            r = {dq, 16'h0000};
         end else begin
            r = {16'h0000, dq};
         end
      end else if (ph) begin
         r = {dq, old[15:0]};
      end else begin
         r = {old[31:16], dq};
      end
      return r;
   endfunction

   // Acceptance test, end-of-phase decode and read-data merge.
   always_comb begin
      accept_s      = (rd | wr) & ~stallX & (state_r == ST_IDLE) & (adr[23:21] == 3'd0);
      active_last_s = (state_r == ST_ACTIVE) && (ws_cnt_r == 4'd0);
      phase_done_s  = (active_last_s && !wr_r) || (state_r == ST_RECOV);
      more_phase_s  = !ben_r && !phase_r;
      rd_merge_s    = merge_read(inbus, sram_dq_in, ben_r, adr_r[1], phase_r);
   end

   // Phase sequencer; every output is loaded with the value for the state being entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         ws_cnt_r    <= 4'd0;
         adr_r       <= 20'd0;
         ben_r       <= 1'b0;
         wr_r        <= 1'b0;
         phase_r     <= 1'b0;
         data_hi_r   <= 16'h0000;
         inbus       <= 32'h0000_0000;
         stallX      <= 1'b0;
         sram_adr    <= 20'd0;
         sram_dq_out <= 16'h0000;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_ub_n   <= 1'b1;
         sram_lb_n   <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  adr_r      <= adr[20:1];
                  ben_r      <= ben;
                  wr_r       <= wr;
                  phase_r    <= 1'b0;
                  data_hi_r  <= outbus[31:16];
                  state_r    <= ST_SETUP;
                  stallX     <= 1'b1;
                  sram_adr   <= first_adr(adr[20:0], ben);
                  {sram_ub_n, sram_lb_n} <= lanes_n(ben, adr[0]);
                  sram_ce_n  <= 1'b0;
                  sram_oe_n  <= 1'b1;
                  sram_we_n  <= 1'b1;
                  sram_dq_oe <= wr;
                  if (wr) begin
                     sram_dq_out <= first_dq(outbus, ben);
                  end else begin
                     sram_dq_out <= sram_dq_out;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               state_r   <= ST_ACTIVE;
               ws_cnt_r  <= WS_LAST;
               sram_oe_n <= wr_r;
               sram_we_n <= ~wr_r;
            end
            ST_ACTIVE: begin
               if (!active_last_s) begin
                  ws_cnt_r <= ws_cnt_r - 4'd1;
               end else if (wr_r) begin
                  state_r   <= ST_RECOV;
                  sram_we_n <= 1'b1;
               end else begin
                  // Read data is sampled on the edge that ends the last ACTIVE cycle.
                  inbus <= rd_merge_s;
               end
            end
            ST_RECOV: begin
               state_r <= ST_RECOV;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase

         // Leaving a phase: start the HI phase of a word or release the bus.
         if (phase_done_s) begin
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (more_phase_s) begin
               phase_r  <= 1'b1;
               state_r  <= ST_SETUP;
               sram_adr <= {adr_r[20:2], 1'b1};
               if (wr_r) begin
                  sram_dq_out <= data_hi_r;
               end else begin
                  sram_dq_out <= sram_dq_out;
               end
            end else begin
               state_r    <= ST_IDLE;
               stallX     <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_ub_n  <= 1'b1;
               sram_lb_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram16_responder.sv
// Directed bench for sram16_responder with a behavioural asynchronous SRAM.
module tb_sram16_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] adr = 24'h000000;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic        ben = 1'b0;
   logic [31:0] outbus = 32'h0;
   logic [31:0] inbus;
   logic        stallX;
   logic [19:0] sram_adr;
   logic [15:0] sram_dq_in;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   logic [15:0] mem [0:255];
   bit          mem_ready = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   int          we_low_total  = 0;
   int          we_fall_total = 0;
   int          hazard_total  = 0;
   logic        prev_we_n = 1'b1;
   logic [19:0] prev_adr  = 20'h0;
   logic [15:0] prev_dq   = 16'h0;
   logic [19:0] last_we_adr = 20'h0;
   logic [1:0]  last_we_lanes = 2'b11;

   int cyc;
   int low0, fall0, haz0;

   sram16_responder #(.WS(2)) dut (
      .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben),
      .outbus(outbus), .inbus(inbus), .stallX(stallX), .sram_adr(sram_adr),
      .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM read: only enabled lanes drive, others read as zero.
   assign sram_dq_in = (!sram_ce_n && !sram_oe_n)
      ? {(sram_ub_n ? 8'h00 : mem[sram_adr[7:0]][15:8]),
         (sram_lb_n ? 8'h00 : mem[sram_adr[7:0]][7:0])}
      : 16'hF00F;

   // SRAM array: preload once, then write enabled lanes for each cycle with we_n low.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem[8'h01] <= 16'h0011;
         mem[8'h20] <= 16'h1234;
         mem[8'h21] <= 16'hABCD;
         mem_ready <= 1'b1;
      end else if (rst && !sram_ce_n && !sram_we_n && sram_dq_oe) begin
         if (!sram_ub_n) mem[sram_adr[7:0]][15:8] <= sram_dq_out[15:8];
         if (!sram_lb_n) mem[sram_adr[7:0]][7:0]  <= sram_dq_out[7:0];
      end
   end

   // Write-strobe monitor: counts we_n low cycles and flags address/data motion around them.
   always @(negedge clk) begin
      if (rst) begin
         if (sram_we_n === 1'b0) begin
            we_low_total  <= we_low_total + 1;
            last_we_adr   <= sram_adr;
            last_we_lanes <= {sram_ub_n, sram_lb_n};
            if (prev_we_n === 1'b1) we_fall_total <= we_fall_total + 1;
            if (sram_adr !== prev_adr || sram_dq_out !== prev_dq || sram_dq_oe !== 1'b1)
               hazard_total <= hazard_total + 1;
         end else if (prev_we_n === 1'b0) begin
            if (sram_adr !== prev_adr || sram_dq_out !== prev_dq)
               hazard_total <= hazard_total + 1;
         end
      end
      prev_we_n <= sram_we_n;
      prev_adr  <= sram_adr;
      prev_dq   <= sram_dq_out;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request for one cycle (starting #1 after an edge), then count stall cycles.
   // inj_at > 0 presents an extra read strobe during that stall cycle.
   task automatic do_req(input logic r, input logic w, input logic b,
                         input logic [23:0] a, input logic [31:0] d,
                         input int inj_at, output int cycles);
      rd = r; wr = w; ben = b; adr = a; outbus = d;
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0; ben = ~b; adr = 24'h000010; outbus = ~d;
      cycles = 0;
      while (stallX === 1'b1 && cycles < 64) begin
         cycles++;
         if (cycles == inj_at) rd = 1'b1;
         else rd = 1'b0;
         @(posedge clk); #1;
      end
      rd = 1'b0;
   endtask

   initial begin
      // Reset state
      #3 rst = 1'b0;
      #1;
      check("rst_ctrl", {25'h0, stallX, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe},
            {25'h0, 7'b0111110});
      check("rst_inbus", inbus, 32'h0);
      check("rst_adr", {12'h0, sram_adr}, 32'h0);
      check("rst_dq", {16'h0, sram_dq_out}, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // Word read of 0x40 -> halfwords 0x20 (LO) and 0x21 (HI)
      do_req(1'b1, 1'b0, 1'b0, 24'h000040, 32'h0, 0, cyc);
      check("wrd_stall", cyc, 6);
      check("wrd_data", inbus, 32'hABCD1234);
      check("wrd_idle_ce", {31'h0, sram_ce_n}, 32'h1);

      // Word write of 0x44 -> halfwords 0x22/0x23
      low0 = we_low_total; fall0 = we_fall_total; haz0 = hazard_total;
      do_req(1'b0, 1'b1, 1'b0, 24'h000044, 32'hDEADBEEF, 0, cyc);
      check("wwr_stall", cyc, 8);
      check("wwr_lo", {16'h0, mem[8'h22]}, 32'h0000BEEF);
      check("wwr_hi", {16'h0, mem[8'h23]}, 32'h0000DEAD);
      check("wwr_we_low", we_low_total - low0, 4);
      check("wwr_we_fall", we_fall_total - fall0, 2);
      check("wwr_hazard", hazard_total - haz0, 0);
      check("wwr_inbus", inbus, 32'hABCD1234);

      // Byte write to 0x3 -> halfword 1, upper lane only
      low0 = we_low_total;
      do_req(1'b0, 1'b1, 1'b1, 24'h000003, 32'h5A5A5A5A, 0, cyc);
      check("bwr_stall", cyc, 4);
      check("bwr_adr", {12'h0, last_we_adr}, 32'h00001);
      check("bwr_lanes", {30'h0, last_we_lanes}, 32'h1);
      check("bwr_mem", {16'h0, mem[8'h01]}, 32'h00005A11);
      check("bwr_we_low", we_low_total - low0, 2);

      // Byte read of 0x3 -> upper half of inbus
      do_req(1'b1, 1'b0, 1'b1, 24'h000003, 32'h0, 0, cyc);
      check("brd_stall", cyc, 3);
      check("brd_data", inbus, 32'h5A000000);

      // Out-of-range read is ignored
      do_req(1'b1, 1'b0, 1'b0, 24'hFFFFC0, 32'h0, 0, cyc);
      check("oor_stall", cyc, 0);
      check("oor_ce", {31'h0, sram_ce_n}, 32'h1);
      check("oor_inbus", inbus, 32'h5A000000);

      // rd and wr together at 0 is a word write
      do_req(1'b1, 1'b1, 1'b0, 24'h000000, 32'h13579BDF, 0, cyc);
      check("rw_stall", cyc, 8);
      check("rw_lo", {16'h0, mem[8'h00]}, 32'h00009BDF);
      check("rw_hi", {16'h0, mem[8'h01]}, 32'h00001357);
      check("rw_inbus", inbus, 32'h5A000000);

      // Reset during the HI ACTIVE phase of a word write to 0x80
      rd = 1'b0; wr = 1'b1; ben = 1'b0; adr = 24'h000080; outbus = 32'h11112222;
      @(posedge clk); #1;
      wr = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_we_low", {31'h0, sram_we_n}, 32'h0);
      check("mid_adr", {12'h0, sram_adr}, 32'h00041);
      rst = 1'b0;
      #1;
      check("mid_rst_ctrl", {25'h0, stallX, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe},
            {25'h0, 7'b0111110});
      check("mid_rst_inbus", inbus, 32'h0);
      check("mid_rst_adr", {12'h0, sram_adr}, 32'h0);
      check("mid_rst_dq", {16'h0, sram_dq_out}, 32'h0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      do_req(1'b1, 1'b0, 1'b0, 24'h000040, 32'h0, 0, cyc);
      check("post_rst_stall", cyc, 6);
      check("post_rst_data", inbus, 32'hABCD1234);

      // Write with a strobe during the stall, then a read in the first free cycle
      do_req(1'b0, 1'b1, 1'b0, 24'h000048, 32'hCAFEF00D, 3, cyc);
      check("b2b_wr_stall", cyc, 8);
      do_req(1'b1, 1'b0, 1'b0, 24'h000048, 32'h0, 0, cyc);
      check("b2b_rd_stall", cyc, 6);
      check("b2b_rd_data", inbus, 32'hCAFEF00D);
      @(posedge clk); #1;
      check("b2b_quiet", {31'h0, stallX}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
